// File: rtl/sram_controller_if.sv
// ---------------------------------------------------------------------------
// sram_controller_if
//   Request-side bundle between the LC-3 memory datapath (MAR/MDR side) and
//   the SRAM controller.
//
//   Req     requester -> controller  request, sampled only while idle
//   Rw      requester -> controller  1 = write, 0 = read
//   Addr    requester -> controller  word address
//   WData   requester -> controller  write data
//   ByteEn  requester -> controller  [0] low byte, [1] high byte
//   RData   controller -> requester  captured read data
//   Ready   controller -> requester  one-cycle completion pulse
//   Busy    controller -> requester  high whenever an access is in flight
// ---------------------------------------------------------------------------
interface sram_controller_if #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16
);
   logic              Req;
   logic              Rw;
   logic [ADDR_W-1:0] Addr;
   logic [DATA_W-1:0] WData;
   logic [1:0]        ByteEn;
   logic [DATA_W-1:0] RData;
   logic              Ready;
   logic              Busy;

   modport master (
      output Req, Rw, Addr, WData, ByteEn,
      input  RData, Ready, Busy
   );

   modport slave (
      input  Req, Rw, Addr, WData, ByteEn,
      output RData, Ready, Busy
   );
endinterface

// File: rtl/sram_controller.sv
// ---------------------------------------------------------------------------
// sram_controller
//   Sequences one asynchronous SRAM access per accepted request:
//   IDLE -> SETUP -> ACCESS (WAIT_CYCLES cycles) -> HOLD -> IDLE.
//   All SRAM strobes, byte enables and the address are registered; the DQ
//   output enable is registered too, so DQ only ever changes on a clock edge
//   or on reset. Read data is captured on the edge that leaves ACCESS.
//
//   Clk     in     system clock, rising edge
//   Reset   in     asynchronous, active-low reset
//   bus     slave  request bundle (Req/Rw/Addr/WData/ByteEn/RData/Ready/Busy)
//   CE      out    chip enable, active-low
//   OE      out    output enable, active-low
//   WE      out    write enable, active-low
//   LB      out    low-byte enable, active-low
//   UB      out    high-byte enable, active-low
//   ADDR    out    SRAM word address
//   DQ      inout  SRAM data bus
// ---------------------------------------------------------------------------
module sram_controller #(
   parameter int WAIT_CYCLES = 1,
   parameter int ADDR_W      = 20,
   parameter int DATA_W      = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   sram_controller_if.slave  bus,
   output logic              CE,
   output logic              OE,
   output logic              WE,
   output logic              LB,
   output logic              UB,
   output logic [ADDR_W-1:0] ADDR,
   inout  wire  [DATA_W-1:0] DQ
);

   localparam int LANE_W = DATA_W / 2;

   if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
      $error("sram_controller: WAIT_CYCLES must be in 1..15");
   end

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      HOLD   = 2'd3
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [3:0]        cnt;
   logic              rw_lat;
   logic [1:0]        be_lat;
   logic [DATA_W-1:0] wdata_lat;
   logic              dq_en;
   logic              accept;

   logic              rw_cur;
   logic [1:0]        be_cur;
   logic              ce_nxt;
   logic              oe_nxt;
   logic              we_nxt;
   logic              lb_nxt;
   logic              ub_nxt;
   logic              dq_en_nxt;
   logic              ready_nxt;

   // Lanes whose byte enable is clear read back as zero.
   function automatic logic [DATA_W-1:0] mask_lanes(input logic [DATA_W-1:0] d,
                                                    input logic [1:0]        be);
      logic [DATA_W-1:0] m;
      m = d;
      if (!be[0]) m[LANE_W-1:0]      = '0;
      if (!be[1]) m[DATA_W-1:LANE_W] = '0;
      return m;
   endfunction

   assign accept   = (state == IDLE) && bus.Req;
   assign bus.Busy = (state != IDLE);
   assign DQ       = dq_en ? wdata_lat : {DATA_W{1'bz}};

   // Outputs are registered, so they are decoded from the state being
   // entered. On the accepting edge the latches are not loaded yet, hence
   // the request inputs are used directly while idle.
   always_comb begin
      next_state = state;
      rw_cur     = rw_lat;
      be_cur     = be_lat;
      ce_nxt     = 1'b1;
      oe_nxt     = 1'b1;
      we_nxt     = 1'b1;
      lb_nxt     = 1'b1;
      ub_nxt     = 1'b1;
      dq_en_nxt  = 1'b0;
      ready_nxt  = 1'b0;

      if (state == IDLE) begin
         rw_cur = bus.Rw;
         be_cur = bus.ByteEn;
      end

      case (state)
         IDLE:    if (bus.Req) next_state = SETUP;
         SETUP:   next_state = ACCESS;
         ACCESS:  if (cnt == 4'd0) next_state = HOLD;
         HOLD:    next_state = IDLE;
         default: next_state = IDLE;
      endcase

      case (next_state)
         SETUP: begin
            ce_nxt    = 1'b0;
            lb_nxt    = ~be_cur[0];
            ub_nxt    = ~be_cur[1];
            oe_nxt    = rw_cur;
            dq_en_nxt = rw_cur;
         end
         ACCESS: begin
            ce_nxt    = 1'b0;
            lb_nxt    = ~be_cur[0];
            ub_nxt    = ~be_cur[1];
            oe_nxt    = rw_cur;
            we_nxt    = ~rw_cur;
            dq_en_nxt = rw_cur;
         end
         HOLD: begin
            // Write data stays on DQ one cycle past the WE rise.
            dq_en_nxt = rw_cur;
            ready_nxt = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         rw_lat    <= 1'b0;
         be_lat    <= 2'b00;
         CE        <= 1'b1;
         OE        <= 1'b1;
         WE        <= 1'b1;
         LB        <= 1'b1;
         UB        <= 1'b1;
         ADDR      <= '0;
         dq_en     <= 1'b0;
         bus.Ready <= 1'b0;
         bus.RData <= '0;
      end else begin
         state     <= next_state;
         CE        <= ce_nxt;
         OE        <= oe_nxt;
         WE        <= we_nxt;
         LB        <= lb_nxt;
         UB        <= ub_nxt;
         dq_en     <= dq_en_nxt;
         bus.Ready <= ready_nxt;

         if (accept) begin
            rw_lat <= bus.Rw;
            be_lat <= bus.ByteEn;
            ADDR   <= bus.Addr;
         end

         if (state == SETUP) begin
            cnt <= CNT_LOAD;
         end else if (state == ACCESS && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end

         // Sample DQ on the edge that closes the read strobe.
         if (state == ACCESS && cnt == 4'd0 && !rw_lat) begin
            bus.RData <= mask_lanes(DQ, be_lat);
         end
      end
   end

   // Write data is a pure datapath latch; only the accept edge loads it.
   always_ff @(posedge Clk) begin
      if (accept) wdata_lat <= bus.WData;
   end

endmodule

// File: tb/tb_sram_controller.sv
// ---------------------------------------------------------------------------
// tb_sram_controller
//   Drives sram_controller (WAIT_CYCLES=1) against a cycle-level SRAM model,
//   plus a WAIT_CYCLES=3 instance against a fixed-data SRAM stub.
// ---------------------------------------------------------------------------
module tb_sram_controller;

   logic Clk;
   logic Reset;

   sram_controller_if #(.ADDR_W(20), .DATA_W(16)) bus1 ();
   sram_controller_if #(.ADDR_W(20), .DATA_W(16)) bus3 ();

   wire        ce1, oe1, we1, lb1, ub1;
   wire [19:0] addr1;
   wire [15:0] dq1;
   wire        ce3, oe3, we3, lb3, ub3;
   wire [19:0] addr3;
   wire [15:0] dq3;

   sram_controller #(.WAIT_CYCLES(1), .ADDR_W(20), .DATA_W(16)) dut1 (
      .Clk(Clk), .Reset(Reset), .bus(bus1),
      .CE(ce1), .OE(oe1), .WE(we1), .LB(lb1), .UB(ub1),
      .ADDR(addr1), .DQ(dq1)
   );

   sram_controller #(.WAIT_CYCLES(3), .ADDR_W(20), .DATA_W(16)) dut3 (
      .Clk(Clk), .Reset(Reset), .bus(bus3),
      .CE(ce3), .OE(oe3), .WE(we3), .LB(lb3), .UB(ub3),
      .ADDR(addr3), .DQ(dq3)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // SRAM model for dut1: 1K words, aliased on the low address bits.
   logic [15:0] mem [0:1023];
   bit          mem_init = 1'b0;
   logic [15:0] rd_word;

   always_comb rd_word = mem[addr1[9:0]];
   assign dq1 = (!ce1 && !oe1 && we1) ? rd_word : 16'bz;

   always @(posedge Clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
         mem[1]   <= 16'h102F;
         mem_init <= 1'b1;
      end else if (!ce1 && !we1) begin
         if (!lb1) mem[addr1[9:0]][7:0]  <= dq1[7:0];
         if (!ub1) mem[addr1[9:0]][15:8] <= dq1[15:8];
      end
   end

   // Stub for dut3: drives a fixed word whenever a read strobe is active.
   assign dq3 = (!ce3 && !oe3) ? 16'hA5C3 : 16'bz;

   int overlap_cnt = 0;
   int contention_cnt = 0;
   always @(negedge Clk) begin
      if (!oe1 && !we1) overlap_cnt <= overlap_cnt + 1;
      if (dut1.dq_en && !ce1 && !oe1) contention_cnt <= contention_cnt + 1;
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference memory: word array plus byte-lane rules.
   logic [15:0] ref_mem [0:1023];

   task automatic ref_write(input logic [19:0] a, input logic [15:0] d, input logic [1:0] be);
      if (be[0]) ref_mem[a[9:0]][7:0]  = d[7:0];
      if (be[1]) ref_mem[a[9:0]][15:8] = d[15:8];
   endtask

   function automatic logic [15:0] ref_read(input logic [19:0] a, input logic [1:0] be);
      logic [15:0] w;
      w = ref_mem[a[9:0]];
      return {(be[1] ? w[15:8] : 8'h00), (be[0] ? w[7:0] : 8'h00)};
   endfunction

   // One access on dut1, starting at a negedge with the controller idle.
   // Cycle k after acceptance: 1 = SETUP, 2 = ACCESS, 3 = HOLD.
   task automatic do_op(input logic rw, input logic [19:0] addr, input logic [15:0] wdata,
                        input logic [1:0] be, input bit scramble, output logic [15:0] rdata);
      bit seen;
      logic [5:0] exp_pins;
      seen  = 0;
      rdata = 16'h0000;
      bus1.Req = 1'b1; bus1.Rw = rw; bus1.Addr = addr; bus1.WData = wdata; bus1.ByteEn = be;
      for (int k = 1; k <= 8; k++) begin
         @(negedge Clk);
         if (k <= 3) begin
            // {CE, OE, WE, LB, UB, dq driven}
            exp_pins = {(k == 3), ((k == 3) ? 1'b1 : rw), ((k == 2) ? ~rw : 1'b1),
                        ((k == 3) ? 1'b1 : ~be[0]), ((k == 3) ? 1'b1 : ~be[1]), rw};
            check($sformatf("pins_k%0d", k), {26'd0, ce1, oe1, we1, lb1, ub1, dut1.dq_en}, {26'd0, exp_pins});
            check("addr", {12'd0, addr1}, {12'd0, addr});
            check($sformatf("ready_k%0d", k), {31'd0, bus1.Ready}, {31'd0, (k == 3)});
            check("busy", {31'd0, bus1.Busy}, 32'd1);
         end
         if (bus1.Ready) begin
            seen     = 1;
            rdata    = bus1.RData;
            bus1.Req = 1'b0;
            break;
         end
         if (scramble) begin
            bus1.Rw = 1'($urandom); bus1.Addr = 20'($urandom);
            bus1.WData = 16'($urandom); bus1.ByteEn = 2'($urandom);
         end
      end
      if (!seen) begin
         bus1.Req = 1'b0;
         check("ready_timeout", 32'd0, 32'd1);
      end
      @(negedge Clk);
      check("busy_after", {31'd0, bus1.Busy}, 32'd0);
   endtask

   typedef struct {
      logic        rw;
      logic [19:0] addr;
      logic [15:0] wdata;
      logic [1:0]  be;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [10];

   initial begin
      logic [15:0] rd;
      bit          ready_seen;
      logic        rw;
      logic [19:0] addr;
      logic [15:0] wdata;
      logic [1:0]  be;

      vecs[0] = '{1'b0, 20'd1,  16'h0000, 2'b11, 16'h102F};
      vecs[1] = '{1'b1, 20'd10, 16'hBEEF, 2'b11, 16'h0000};
      vecs[2] = '{1'b0, 20'd10, 16'h0000, 2'b11, 16'hBEEF};
      vecs[3] = '{1'b1, 20'd10, 16'h1234, 2'b01, 16'h0000};
      vecs[4] = '{1'b0, 20'd10, 16'h0000, 2'b11, 16'hBE34};
      vecs[5] = '{1'b0, 20'd10, 16'h0000, 2'b10, 16'hBE00};
      vecs[6] = '{1'b0, 20'd1,  16'h0000, 2'b00, 16'h0000};
      vecs[7] = '{1'b1, 20'd1,  16'hFFFF, 2'b00, 16'h0000};
      vecs[8] = '{1'b0, 20'd1,  16'h0000, 2'b11, 16'h102F};
      vecs[9] = '{1'b0, 20'd5,  16'h0000, 2'b11, 16'h0000};

      for (int i = 0; i < 1024; i++) ref_mem[i] = 16'h0000;
      ref_mem[1] = 16'h102F;

      bus1.Req = 1'b0; bus1.Rw = 1'b0; bus1.Addr = '0; bus1.WData = '0; bus1.ByteEn = 2'b00;
      bus3.Req = 1'b0; bus3.Rw = 1'b0; bus3.Addr = '0; bus3.WData = '0; bus3.ByteEn = 2'b00;

      Reset = 1'b1;
      #2 Reset = 1'b0;
      repeat (3) @(negedge Clk);
      check("rst_pins1", {26'd0, ce1, oe1, we1, lb1, ub1, dut1.dq_en}, {26'd0, 6'b111110});
      check("rst_addr1", {12'd0, addr1}, 32'd0);
      check("rst_rdata1", {16'd0, bus1.RData}, 32'd0);
      check("rst_ready_busy1", {30'd0, bus1.Ready, bus1.Busy}, 32'd0);
      check("rst_pins3", {26'd0, ce3, oe3, we3, lb3, ub3, dut3.dq_en}, {26'd0, 6'b111110});
      Reset = 1'b1;
      repeat (2) @(negedge Clk);

      // Abort a write in ACCESS with an asynchronous reset.
      bus1.Req = 1'b1; bus1.Rw = 1'b1; bus1.Addr = 20'd5; bus1.WData = 16'hDEAD; bus1.ByteEn = 2'b11;
      repeat (2) @(negedge Clk);
      check("abort_pre_we", {31'd0, we1}, 32'd0);
      #1 Reset = 1'b0;
      #1;
      check("abort_strobes", {28'd0, ce1, we1, dut1.dq_en, bus1.Busy}, {28'd0, 4'b1100});
      bus1.Req = 1'b0;
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      ready_seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge Clk);
         if (bus1.Ready) ready_seen = 1;
      end
      check("abort_no_ready", {31'd0, ready_seen}, 32'd0);

      // Directed vectors.
      for (int i = 0; i < 10; i++) begin
         do_op(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].be, 0, rd);
         if (vecs[i].rw) ref_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
         else check($sformatf("vec%0d_rdata", i), {16'd0, rd}, {16'd0, vecs[i].exp});
      end

      // Slow instance: three-cycle strobe, request noise while busy.
      bus3.Req = 1'b1; bus3.Rw = 1'b0; bus3.Addr = 20'd7; bus3.ByteEn = 2'b11;
      for (int k = 1; k <= 6; k++) begin
         @(negedge Clk);
         check($sformatf("w3_ce_oe_we_k%0d", k), {29'd0, ce3, oe3, we3},
               {29'd0, ((k <= 4) ? 3'b001 : 3'b111)});
         check($sformatf("w3_ready_k%0d", k), {31'd0, bus3.Ready}, {31'd0, (k == 5)});
         check($sformatf("w3_busy_k%0d", k), {31'd0, bus3.Busy}, {31'd0, (k <= 5)});
         check("w3_addr", {12'd0, addr3}, 32'd7);
         if (k == 5) check("w3_rdata", {16'd0, bus3.RData}, 32'h0000A5C3);
         if (k <= 3) begin
            bus3.Req  = ~bus3.Req;
            bus3.Addr = 20'($urandom);
         end else begin
            bus3.Req = 1'b0;
         end
      end

      // Back-to-back reads with Req held high.
      bus1.Req = 1'b1; bus1.Rw = 1'b0; bus1.Addr = 20'd1; bus1.ByteEn = 2'b11;
      for (int k = 1; k <= 20; k++) begin
         @(negedge Clk);
         check($sformatf("b2b_ready_k%0d", k), {31'd0, bus1.Ready}, {31'd0, (k % 4 == 3)});
         check($sformatf("b2b_ce_k%0d", k), {31'd0, ce1}, {31'd0, !((k % 4 == 1) || (k % 4 == 2))});
         if (k % 4 == 3) check("b2b_rdata", {16'd0, bus1.RData}, 32'h0000102F);
      end
      bus1.Req = 1'b0;
      @(negedge Clk);

      // Random traffic against the reference memory.
      for (int i = 0; i < 40; i++) begin
         rw    = 1'($urandom_range(0, 1));
         addr  = (20'($urandom) & 20'hFFC00) | 20'($urandom_range(0, 15));
         wdata = 16'($urandom);
         be    = 2'($urandom_range(0, 3));
         do_op(rw, addr, wdata, be, 1, rd);
         if (rw) ref_write(addr, wdata, be);
         else check($sformatf("rand%0d_rdata", i), {16'd0, rd}, {16'd0, ref_read(addr, be)});
         repeat ($urandom_range(0, 2)) @(negedge Clk);
      end

      check("oe_we_overlap", overlap_cnt, 32'd0);
      check("dq_contention", contention_cnt, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
